// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver, 16x oversampling, 3-sample majority.
// Define UART_RX_PARITY_EN for 8E1 framing with a checked even-parity bit.
module uart_byte_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_state,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int BAUD_DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          sync_q1;
  logic          sync_q2;
  logic          hist_q;
  logic          fall;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    samp_cnt;
  logic [2:0]    bit_cnt;
  logic          s6_q;
  logic          s7_q;
  logic [7:0]    shift_q;
  logic          tick;
  logic          mid;
  logic          last;
  logic          maj;
  logic          done;

  // Two-flop synchroniser plus history flop for edge detection.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync_q1 <= rs232_rx;
      sync_q2 <= sync_q1;
      hist_q  <= sync_q2;
    end
  end

  assign fall = hist_q & ~sync_q2;

  assign tick = (state_q != IDLE) && (tick_cnt == TICK_MAX);
  assign mid  = tick && (samp_cnt == 4'd8);
  assign last = tick && (samp_cnt == 4'd15);

  // Samples 6 and 7 are stored; sample 8 is the live synced value.
  assign maj = (s6_q & s7_q) |
               (s6_q & sync_q2) |
               (s7_q & sync_q2);

  // State register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; stop is accepted at mid-bit to leave room for resync.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        if (mid && maj) begin
          state_d = IDLE;
        end else if (last) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (last && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (last) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (mid) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tick, sample and bit counters; all held at zero while idle.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      samp_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
    end else if (state_q == IDLE || state_d == IDLE) begin
      tick_cnt <= '0;
      samp_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
    end else begin
      if (tick) begin
        tick_cnt <= '0;
        samp_cnt <= samp_cnt + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      if (state_q == DATA && last) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  // Capture majority samples and shift data in LSB-first.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      s6_q    <= 1'b1;
      s7_q    <= 1'b1;
      shift_q <= 8'h00;
    end else begin
      if (tick && samp_cnt == 4'd6) begin
        s6_q <= sync_q2;
      end
      if (tick && samp_cnt == 4'd7) begin
        s7_q <= sync_q2;
      end
      if (state_q == DATA && mid) begin
        shift_q <= {maj, shift_q[7:1]};
      end
    end
  end

  // Byte delivery, strobe and busy flag.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      rx_state  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done  <= done;
      rx_state <= (state_d != IDLE);
      if (done) begin
        rx_data   <= shift_q;
        frame_err <= ~maj;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q;

  // Parity bit capture and even-parity check at byte delivery.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state_q == PARITY && mid) begin
        par_q <= maj;
      end
      if (done) begin
        parity_err <= (^shift_q) ^ par_q;
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
